// File: rtl/dual_issue_scheduler_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dual_issue_scheduler_pkg : shared defaults, slot-fill encoding, index wrap   |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
package dual_issue_scheduler_pkg;

  localparam int c_REQ_N_DEFAULT = 12;

  // Which slots take a new grant on the coming edge.
  typedef enum logic [1:0] {
    FILL_NONE = 2'd0,
    FILL_S1   = 2'd1,
    FILL_S2   = 2'd2,
    FILL_BOTH = 2'd3
  } fill_e;

  // Modular add for a non-power-of-two ring; both operands are already < n.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dual_issue_scheduler_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dual_issue_scheduler_if : request vector, two issue-slot handshakes, acks    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
interface dual_issue_scheduler_if #(
  parameter int REQ_N = 12,
  parameter int OUT_N = $clog2(REQ_N)
);
  logic [REQ_N-1:0] i_req;
  logic             i_flush;
  logic             o_valid_1;
  logic [OUT_N-1:0] o_idx_1;
  logic             i_ready_1;
  logic             o_valid_2;
  logic [OUT_N-1:0] o_idx_2;
  logic             i_ready_2;
  logic [REQ_N-1:0] o_ack;

  modport master (
    output i_req, i_flush, i_ready_1, i_ready_2,
    input  o_valid_1, o_idx_1, o_valid_2, o_idx_2, o_ack
  );

  modport slave (
    input  i_req, i_flush, i_ready_1, i_ready_2,
    output o_valid_1, o_idx_1, o_valid_2, o_idx_2, o_ack
  );
endinterface
`default_nettype wire

// File: rtl/dual_issue_scheduler_dpe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dual_priority_encoder : positions of the two lowest set bits of i_vec        |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module dual_priority_encoder #(
  parameter int REQ_N = 12,
  parameter int OUT_N = $clog2(REQ_N)
) (
  input  wire logic [REQ_N-1:0] i_vec,
  output logic                  o_valid_a,
  output logic [OUT_N-1:0]      o_idx_a,
  output logic                  o_valid_b,
  output logic [OUT_N-1:0]      o_idx_b
);

  // Scanning downward, each hit becomes the new lowest and demotes the old one.
  always_comb begin
    o_valid_a = 1'b0;
    o_idx_a   = '0;
    o_valid_b = 1'b0;
    o_idx_b   = '0;
    for (int i = REQ_N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_valid_b = o_valid_a;
        o_idx_b   = o_idx_a;
        o_valid_a = 1'b1;
        o_idx_a   = OUT_N'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dual_issue_scheduler : round-robin issue of up to two requesters per cycle   |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module dual_issue_scheduler
  import dual_issue_scheduler_pkg::*;
#(
  parameter int REQ_N = c_REQ_N_DEFAULT,
  parameter int OUT_N = $clog2(REQ_N)
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst,
  dual_issue_scheduler_if.slave  bus
);

  logic             r_valid_1, r_valid_2;
  logic [OUT_N-1:0] r_idx_1, r_idx_2, r_ptr;

  logic             w_acc_1, w_acc_2, w_free_1, w_free_2;
  logic [REQ_N-1:0] w_busy, w_elig, w_rot, w_ack;
  logic             w_va, w_vb;
  logic [OUT_N-1:0] w_enc_a, w_enc_b, w_pick_1, w_pick_2;
  logic [OUT_N-1:0] w_nxt_idx_2, w_last, w_ptr_nxt;
  fill_e            w_fill;

  assign w_acc_1  = r_valid_1 & bus.i_ready_1;
  assign w_acc_2  = r_valid_2 & bus.i_ready_2;
  assign w_free_1 = !r_valid_1 | w_acc_1;
  assign w_free_2 = !r_valid_2 | w_acc_2;

  // Held grants stay masked even while being accepted, so nobody is re-issued early.
  always_comb begin
    w_busy = '0;
    if (r_valid_1) w_busy[r_idx_1] = 1'b1;
    if (r_valid_2) w_busy[r_idx_2] = 1'b1;
  end
  assign w_elig = bus.i_req & ~w_busy;

  always_comb begin
    w_rot = '0;
    for (int j = 0; j < REQ_N; j++) begin
      w_rot[j] = w_elig[OUT_N'(wrap_add(j, int'(r_ptr), REQ_N))];
    end
  end

  dual_priority_encoder #(
    .REQ_N (REQ_N),
    .OUT_N (OUT_N)
  ) u_enc (
    .i_vec     (w_rot),
    .o_valid_a (w_va),
    .o_idx_a   (w_enc_a),
    .o_valid_b (w_vb),
    .o_idx_b   (w_enc_b)
  );

  assign w_pick_1 = OUT_N'(wrap_add(int'(w_enc_a), int'(r_ptr), REQ_N));
  assign w_pick_2 = OUT_N'(wrap_add(int'(w_enc_b), int'(r_ptr), REQ_N));

  always_comb begin
    w_fill      = FILL_NONE;
    w_nxt_idx_2 = w_pick_1;
    w_last      = w_pick_1;
    if (w_free_1 && w_free_2) begin
      if (w_va && w_vb) begin
        w_fill      = FILL_BOTH;
        w_nxt_idx_2 = w_pick_2;
        w_last      = w_pick_2;
      end else if (w_va) begin
        w_fill = FILL_S1;
      end
    end else if (w_free_1) begin
      if (w_va) w_fill = FILL_S1;
    end else if (w_free_2) begin
      if (w_va) w_fill = FILL_S2;
    end
  end

  assign w_ptr_nxt = OUT_N'(wrap_add(int'(w_last), 1, REQ_N));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid_1 <= 1'b0;
      r_valid_2 <= 1'b0;
      r_idx_1   <= '0;
      r_idx_2   <= '0;
      r_ptr     <= '0;
    end else if (bus.i_flush) begin
      r_valid_1 <= 1'b0;
      r_valid_2 <= 1'b0;
    end else begin
      if (w_free_1) begin
        r_valid_1 <= (w_fill == FILL_S1) || (w_fill == FILL_BOTH);
        if ((w_fill == FILL_S1) || (w_fill == FILL_BOTH)) r_idx_1 <= w_pick_1;
      end
      if (w_free_2) begin
        r_valid_2 <= (w_fill == FILL_S2) || (w_fill == FILL_BOTH);
        if ((w_fill == FILL_S2) || (w_fill == FILL_BOTH)) r_idx_2 <= w_nxt_idx_2;
      end
      if (w_fill != FILL_NONE) r_ptr <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_ack = '0;
    if (w_acc_1) w_ack[r_idx_1] = 1'b1;
    if (w_acc_2) w_ack[r_idx_2] = 1'b1;
  end

  assign bus.o_ack     = w_ack;
  assign bus.o_valid_1 = r_valid_1;
  assign bus.o_idx_1   = r_idx_1;
  assign bus.o_valid_2 = r_valid_2;
  assign bus.o_idx_2   = r_idx_2;

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_dual_issue_scheduler : directed vectors against a circular-search model   |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_dual_issue_scheduler;

  localparam int c_N = 12;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  dual_issue_scheduler_if #(.REQ_N(c_N)) bus ();

  dual_issue_scheduler #(.REQ_N(c_N)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: slots plus pointer; picks found by walking the ring from the pointer.
  bit mv1, mv2, m_live;
  int mi1, mi2, mptr;

  always @(posedge clk) begin : m_upd
    logic [c_N-1:0] el;
    int p[2];
    int np, last, c;
    bit f1, f2;
    if (rst) begin
      mv1 = 0; mv2 = 0; mi1 = 0; mi2 = 0; mptr = 0; m_live = 1;
    end else if (m_live) begin
      el = bus.i_req;
      if (mv1) el[mi1] = 1'b0;
      if (mv2) el[mi2] = 1'b0;
      f1 = !mv1 || bus.i_ready_1;
      f2 = !mv2 || bus.i_ready_2;
      if (bus.i_flush) begin
        mv1 = 0; mv2 = 0;
      end else begin
        np = 0; p[0] = 0; p[1] = 0;
        for (int k = 0; k < c_N; k++) begin
          c = (mptr + k) % c_N;
          if (el[c] && np < 2) begin p[np] = c; np++; end
        end
        last = -1;
        if (f1) begin
          mv1 = (np > 0);
          if (np > 0) begin mi1 = p[0]; last = p[0]; end
          if (f2) begin
            mv2 = (np > 1);
            if (np > 1) begin mi2 = p[1]; last = p[1]; end
          end
        end else if (f2) begin
          mv2 = (np > 0);
          if (np > 0) begin mi2 = p[0]; last = p[0]; end
        end
        if (last >= 0) mptr = (last + 1) % c_N;
      end
    end
  end

  always @(negedge clk) begin : m_cmp
    logic [c_N-1:0] eack;
    if (m_live) begin
      eack = '0;
      if (mv1 && bus.i_ready_1) eack[mi1] = 1'b1;
      if (mv2 && bus.i_ready_2) eack[mi2] = 1'b1;
      chk("model_valid_1", 32'(bus.o_valid_1), 32'(mv1));
      chk("model_valid_2", 32'(bus.o_valid_2), 32'(mv2));
      if (mv1) chk("model_idx_1", 32'(bus.o_idx_1), 32'(mi1));
      if (mv2) chk("model_idx_2", 32'(bus.o_idx_2), 32'(mi2));
      chk("model_ack", 32'(bus.o_ack), 32'(eack));
    end
  end

  logic [c_N-1:0] vec_tab [8] = '{12'h0F0, 12'h555, 12'h0AA, 12'hC03,
                                   12'h100, 12'hFFF, 12'h000, 12'h3C9};

  initial begin
    rst = 1'b1;
    bus.i_req = 12'hFFF; bus.i_flush = 1'b0;
    bus.i_ready_1 = 1'b1; bus.i_ready_2 = 1'b1;
    step(); step();
    chk("rst_valid_1", 32'(bus.o_valid_1), 0);
    chk("rst_valid_2", 32'(bus.o_valid_2), 0);
    chk("rst_ack", 32'(bus.o_ack), 0);
    chk("rst_idx_1", 32'(bus.o_idx_1), 0);
    chk("rst_idx_2", 32'(bus.o_idx_2), 0);

    rst = 1'b0;
    step();
    chk("first_idx_1", 32'(bus.o_idx_1), 0);
    chk("first_idx_2", 32'(bus.o_idx_2), 1);
    chk("first_ack", 32'(bus.o_ack), 32'h003);

    for (int p = 1; p < 6; p++) begin
      step();
      chk("rr_idx_1", 32'(bus.o_idx_1), 32'(2 * p));
      chk("rr_idx_2", 32'(bus.o_idx_2), 32'(2 * p + 1));
    end
    step();
    chk("wrap_idx_1", 32'(bus.o_idx_1), 0);
    chk("wrap_idx_2", 32'(bus.o_idx_2), 1);

    bus.i_ready_1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid_1", 32'(bus.o_valid_1), 1);
      chk("bp_idx_1", 32'(bus.o_idx_1), 0);
      chk("bp_idx_2", 32'(bus.o_idx_2), 32'(2 + i));
    end

    bus.i_req = 12'h010; bus.i_ready_1 = 1'b1;
    step();
    chk("single_valid_1", 32'(bus.o_valid_1), 1);
    chk("single_idx_1", 32'(bus.o_idx_1), 4);
    chk("single_valid_2", 32'(bus.o_valid_2), 0);
    chk("single_ack", 32'(bus.o_ack), 32'h010);

    bus.i_req = 12'h801;
    step();
    chk("sparse_idx_1", 32'(bus.o_idx_1), 11);
    chk("sparse_idx_2", 32'(bus.o_idx_2), 0);
    chk("sparse_valid_2", 32'(bus.o_valid_2), 1);

    bus.i_req = 12'hFFF; bus.i_ready_1 = 1'b0; bus.i_ready_2 = 1'b0;
    step();
    chk("hold_idx_1", 32'(bus.o_idx_1), 11);
    chk("hold_idx_2", 32'(bus.o_idx_2), 0);
    bus.i_ready_1 = 1'b1; bus.i_flush = 1'b1;
    #1;
    chk("flush_ack", 32'(bus.o_ack), 32'h800);
    step();
    bus.i_flush = 1'b0;
    chk("flush_valid_1", 32'(bus.o_valid_1), 0);
    chk("flush_valid_2", 32'(bus.o_valid_2), 0);
    chk("flush_ack_after", 32'(bus.o_ack), 0);
    bus.i_ready_2 = 1'b1;
    step();
    chk("post_flush_idx_1", 32'(bus.o_idx_1), 1);
    chk("post_flush_idx_2", 32'(bus.o_idx_2), 2);

    bus.i_ready_1 = 1'b0; bus.i_ready_2 = 1'b0;
    rst = 1'b1; bus.i_flush = 1'b1;
    step();
    chk("midrst_valid_1", 32'(bus.o_valid_1), 0);
    chk("midrst_valid_2", 32'(bus.o_valid_2), 0);
    rst = 1'b0; bus.i_flush = 1'b0; bus.i_ready_1 = 1'b1; bus.i_ready_2 = 1'b1;
    step();
    chk("midrst_idx_1", 32'(bus.o_idx_1), 0);
    chk("midrst_idx_2", 32'(bus.o_idx_2), 1);

    for (int i = 0; i < 24; i++) begin
      bus.i_req     = vec_tab[i % 8];
      bus.i_ready_1 = (i % 3) != 1;
      bus.i_ready_2 = (i % 4) != 2;
      step();
    end

    bus.i_req = '0; bus.i_ready_1 = 1'b1; bus.i_ready_2 = 1'b1;
    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
